addbit_seq: RTL

- Parametrised, multi-cycle successor to the 1-bit gate/RTL adder.
- Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, ripple-style across cycles.
- Operands enter on a valid/ready input handshake; the result leaves on a valid/ready output handshake.
- Sits in test benches and small datapaths as a VPI-inspectable sequential adder with observable internal state (FSM, chunk counter, carry).

---
 rtl/addbit_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/addbit_seq.sv
// Multi-cycle ripple adder: {co,sum} = a + b + ci, CHUNK bits per clock, with valid/ready on both sides.
// Optional signed-overflow output ovf is enabled by defining ADDBIT_SEQ_OVERFLOW_EN.
module addbit_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             busy
`ifdef ADDBIT_SEQ_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("addbit_seq: need 1 <= CHUNK <= WIDTH and WIDTH %% CHUNK == 0");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               co_q, co_d;
    logic               out_valid_q, out_valid_d;
`ifdef ADDBIT_SEQ_OVERFLOW_EN
    logic               ovf_q, ovf_d;
`endif

    // One chunk of the ripple: low CHUNK bits of each shift register plus running carry
    logic [CHUNK:0]     chunk_res;
    logic [CHUNK-1:0]   chunk_s;
    logic               chunk_c;
    logic               last_chunk;

    assign chunk_res  = (CHUNK+1)'(a_sh_q[CHUNK-1:0]) + (CHUNK+1)'(b_sh_q[CHUNK-1:0])
                      + (CHUNK+1)'(carry_q);
    assign chunk_s    = chunk_res[CHUNK-1:0];
    assign chunk_c    = chunk_res[CHUNK];
    assign last_chunk = (cnt_q == CNT_W'(NCHUNK - 1));

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        co_d        = co_q;
        out_valid_d = out_valid_q;
`ifdef ADDBIT_SEQ_OVERFLOW_EN
        ovf_d       = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = ci;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // New chunk enters at the top; after NCHUNK shifts sum is fully aligned
                sum_d   = WIDTH'({chunk_s, sum_q} >> CHUNK);
                a_sh_d  = a_sh_q >> CHUNK;
                b_sh_d  = b_sh_q >> CHUNK;
                carry_d = chunk_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_chunk) begin
                    co_d        = chunk_c;
                    out_valid_d = 1'b1;
`ifdef ADDBIT_SEQ_OVERFLOW_EN
                    // Carry into the MSB recovered from the MSB sum bit
                    ovf_d       = chunk_s[CHUNK-1] ^ a_sh_q[CHUNK-1] ^ b_sh_q[CHUNK-1] ^ chunk_c;
`endif
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
`ifdef ADDBIT_SEQ_OVERFLOW_EN
                    ovf_d       = 1'b0;
`endif
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            co_q        <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef ADDBIT_SEQ_OVERFLOW_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            co_q        <= co_d;
            out_valid_q <= out_valid_d;
`ifdef ADDBIT_SEQ_OVERFLOW_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign co        = co_q;
`ifdef ADDBIT_SEQ_OVERFLOW_EN
    assign ovf       = ovf_q;
`endif

endmodule
